// File: rtl/d_delay_line_pkg.sv
// Shared constants and width helpers for the d_delay_line register pipeline.
package d_delay_line_pkg;

  // Every bit of the default reset word; widened to WIDTH by the user.
  localparam logic DefaultResetBit = 1'b0;

  function automatic int unsigned tap_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/d_ff_en.sv
// WIDTH-bit register with synchronous active-low reset and load enable.
module d_ff_en #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (en_i) q_d = d_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) q_q <= RESET_VALUE;
    else         q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/d_delay_line.sv
// Clock-enabled DEPTH-stage word pipeline with per-stage valid bits, flush,
// a selectable read tap and a registered occupancy count.
module d_delay_line
  import d_delay_line_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{DefaultResetBit}},
  localparam int unsigned     TAP_W       = tap_width(DEPTH),
  localparam int unsigned     OCC_W       = occ_width(DEPTH)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] D,
  input  logic             D_valid,
  input  logic             CE,
  input  logic             Flush,
  input  logic [TAP_W-1:0] Tap_sel,
  output logic [WIDTH-1:0] Q,
  output logic             Q_valid,
  output logic [WIDTH-1:0] Tap,
  output logic             Tap_valid,
  output logic [OCC_W-1:0] Occupancy
);

  localparam int unsigned SumW = OCC_W + 1;

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [DEPTH-1:0] valid_d, valid_q;
  logic [OCC_W-1:0] occ_d, occ_q;
  logic [SumW-1:0]  occ_sum;
  logic             stage_en;

  // Flush freezes stage data so the cleared words stay observable on the tap.
  assign stage_en = CE & ~Flush;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] stage_in;
    if (g == 0) begin : g_head
      assign stage_in = D;
    end else begin : g_body
      assign stage_in = stage_q[g-1];
    end
    d_ff_en #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_ff (
      .clk_i  (CLK),
      .rst_ni (Reset),
      .en_i   (stage_en),
      .d_i    (stage_in),
      .q_o    (stage_q[g])
    );
  end

  always_comb begin
    valid_d = valid_q;
    occ_d   = occ_q;
    occ_sum = {1'b0, occ_q} + SumW'(D_valid) - SumW'(valid_q[DEPTH-1]);
    if (Flush) begin
      valid_d = '0;
      occ_d   = '0;
    end else if (CE) begin
      valid_d[0] = D_valid;
      for (int i = 1; i < DEPTH; i++) valid_d[i] = valid_q[i-1];
      occ_d = occ_sum[OCC_W-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  // The sum never exceeds DEPTH, so its top bit is always zero.
  logic unused_occ_msb;
  assign unused_occ_msb = occ_sum[OCC_W];

  always_comb begin
    Tap       = RESET_VALUE;
    Tap_valid = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (Tap_sel == TAP_W'(i)) begin
        Tap       = stage_q[i];
        Tap_valid = valid_q[i];
      end
    end
  end

  assign Q         = stage_q[DEPTH-1];
  assign Q_valid   = valid_q[DEPTH-1];
  assign Occupancy = occ_q;

endmodule

// File: tb/tb_d_delay_line.sv
// Bench for d_delay_line: DEPTH=4 and DEPTH=3 instances against a shift-array model.
module tb_d_delay_line;

  logic       CLK = 1'b0;
  logic       Reset, D_valid, CE, Flush;
  logic [7:0] D;
  logic [1:0] Tap_sel;

  logic [7:0] q4, tap4, q3, tap3;
  logic       qv4, tv4, qv3, tv3;
  logic [2:0] occ4;
  logic [1:0] occ3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  d_delay_line #(.WIDTH(8), .DEPTH(4)) u_dut4 (
    .CLK(CLK), .Reset(Reset), .D(D), .D_valid(D_valid), .CE(CE), .Flush(Flush),
    .Tap_sel(Tap_sel), .Q(q4), .Q_valid(qv4), .Tap(tap4), .Tap_valid(tv4), .Occupancy(occ4)
  );

  d_delay_line #(.WIDTH(8), .DEPTH(3)) u_dut3 (
    .CLK(CLK), .Reset(Reset), .D(D), .D_valid(D_valid), .CE(CE), .Flush(Flush),
    .Tap_sel(Tap_sel), .Q(q3), .Q_valid(qv3), .Tap(tap3), .Tap_valid(tv3), .Occupancy(occ3)
  );

  // Model: index 0 is the newest word, per instance k (0 -> DEPTH 4, 1 -> DEPTH 3).
  logic [7:0] m_data  [2][4];
  logic       m_valid [2][4];
  int         dep     [2] = '{4, 3};

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (!Reset) begin
        for (int i = 0; i < 4; i++) begin
          m_data[k][i]  = 8'h00;
          m_valid[k][i] = 1'b0;
        end
      end else if (Flush) begin
        for (int i = 0; i < 4; i++) m_valid[k][i] = 1'b0;
      end else if (CE) begin
        for (int i = dep[k] - 1; i > 0; i--) begin
          m_data[k][i]  = m_data[k][i-1];
          m_valid[k][i] = m_valid[k][i-1];
        end
        m_data[k][0]  = D;
        m_valid[k][0] = D_valid;
      end
    end
  endtask

  function automatic int m_occ(input int k);
    int n = 0;
    for (int i = 0; i < dep[k]; i++) n += int'(m_valid[k][i]);
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    int s;
    s = int'(Tap_sel);
    chk("q4", 32'(q4), 32'(m_data[0][3]));
    chk("qv4", 32'(qv4), 32'(m_valid[0][3]));
    chk("occ4", 32'(occ4), 32'(m_occ(0)));
    chk("tap4", 32'(tap4), 32'(m_data[0][s]));
    chk("tv4", 32'(tv4), 32'(m_valid[0][s]));
    chk("q3", 32'(q3), 32'(m_data[1][2]));
    chk("qv3", 32'(qv3), 32'(m_valid[1][2]));
    chk("occ3", 32'(occ3), 32'(m_occ(1)));
    chk("tap3", 32'(tap3), (s < 3) ? 32'(m_data[1][s]) : 32'h0);
    chk("tv3", 32'(tv3), (s < 3) ? 32'(m_valid[1][s]) : 32'h0);
  endtask

  task automatic step();
    @(posedge CLK);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input logic r, input logic [7:0] d, input logic dv, input logic ce,
                       input logic fl);
    Reset = r; D = d; D_valid = dv; CE = ce; Flush = fl;
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] d;
    logic       dv;
    logic       ce;
    logic       flush;
    logic [7:0] exp_q;
    logic       exp_qv;
    logic [2:0] exp_occ;
  } vec_t;

  vec_t vecs [7];

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) begin
        m_data[k][i]  = 8'h00;
        m_valid[k][i] = 1'b0;
      end
    Tap_sel = 2'd3;
    drive(1'b0, 8'hFF, 1'b1, 1'b1, 1'b1);

    // Reset dominance, then streaming on DEPTH=4
    vecs[0] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 3'd0};
    vecs[1] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 3'd0};
    vecs[2] = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd1};
    vecs[3] = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd2};
    vecs[4] = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd3};
    vecs[5] = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 3'd4};
    vecs[6] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 8'h22, 1'b1, 3'd4};
    for (int v = 0; v < 7; v++) begin
      drive(vecs[v].rst, vecs[v].d, vecs[v].dv, vecs[v].ce, vecs[v].flush);
      step();
      chk($sformatf("vec%0d_q", v), 32'(q4), 32'(vecs[v].exp_q));
      chk($sformatf("vec%0d_qv", v), 32'(qv4), 32'(vecs[v].exp_qv));
      chk($sformatf("vec%0d_occ", v), 32'(occ4), 32'(vecs[v].exp_occ));
    end

    // Stall and bubbles
    drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b1); step();
    drive(1'b1, 8'hA1, 1'b1, 1'b1, 1'b0); step();
    drive(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0); step();
    drive(1'b1, 8'hA2, 1'b1, 1'b1, 1'b0); step();
    drive(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("stall_occ", 32'(occ4), 32'd2);
      chk("stall_qv", 32'(qv4), 32'd0);
    end
    drive(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    step(); chk("resume1_q", 32'(q4), 32'hA1); chk("resume1_qv", 32'(qv4), 32'd1);
    step(); chk("resume2_q", 32'(q4), 32'hEE); chk("resume2_qv", 32'(qv4), 32'd0);
    step(); chk("resume3_q", 32'(q4), 32'hA2); chk("resume3_qv", 32'(qv4), 32'd1);

    // Flush with simultaneous capture
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hB0 + 8'(i), 1'b1, 1'b1, 1'b0); step();
    end
    drive(1'b1, 8'h77, 1'b1, 1'b1, 1'b1); step();
    chk("flush_occ", 32'(occ4), 32'd0);
    drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 4; s++) begin
      Tap_sel = 2'(s);
      #1;
      chk("flush_tv", 32'(tv4), 32'd0);
      chk("flush_tap", 32'(tap4), 32'(8'hB3 - 8'(s)));
    end
    drive(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("no_77", 32'(q4 == 8'h77), 32'd0);
    end

    // Tap sweep, and DEPTH=3 out-of-range tap
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hA0 + 8'(i), 1'b1, 1'b1, 1'b0); step();
    end
    drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 4; s++) begin
      Tap_sel = 2'(s);
      #1;
      chk("sweep_tap", 32'(tap4), 32'(8'hA3 - 8'(s)));
      chk("sweep_tv", 32'(tv4), 32'd1);
    end
    chk("tap3_eq_q", 32'(q4), 32'hA0);
    chk("oor_tap3", 32'(tap3), 32'h00);
    chk("oor_tv3", 32'(tv3), 32'd0);

    // Mid-stream reset
    drive(1'b0, 8'h5A, 1'b1, 1'b1, 1'b0); step();
    chk("mrst_q4", 32'(q4), 32'h0);  chk("mrst_occ4", 32'(occ4), 32'd0);
    chk("mrst_q3", 32'(q3), 32'h0);  chk("mrst_occ3", 32'(occ3), 32'd0);
    chk("mrst_tv3", 32'(tv3), 32'd0); chk("mrst_qv3", 32'(qv3), 32'd0);

    // Randomised traffic against the model
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 49) != 0), 8'($urandom), 1'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
      Tap_sel = 2'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
